// File: rtl/fifo_stream_pkg.sv
// Shared types and parameter helpers for the FIFO-to-stream reader.
package fifo_stream_pkg;

    typedef enum logic [0:0] {
        ST_RUN   = 1'b0,
        ST_FLUSH = 1'b1
    } state_t;

    localparam int STAT_WIDTH = 32;

    // Smallest output buffer that still sustains one beat per cycle for a given read latency.
    function automatic int min_depth(input int rdlat);
        return rdlat + 2;
    endfunction

endpackage

// File: rtl/sfifo_small.sv
// Small synchronous FIFO used as the output buffer of fifo_stream_rd.
// Exposes its occupancy so the reader can do credit accounting.
module sfifo_small #(
    parameter int WIDTH = 8,
    parameter int DEPTH = 4,
    localparam int CW   = $clog2(DEPTH + 1),
    localparam int PTRW = (DEPTH > 1) ? $clog2(DEPTH) : 1
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             clear,
    input  logic             push,
    input  logic [WIDTH-1:0] push_data,
    input  logic             pop,
    output logic [WIDTH-1:0] head,
    output logic [CW-1:0]    occupancy
);

    logic [WIDTH-1:0] mem [DEPTH];
    logic [PTRW-1:0]  wr_ptr;
    logic [PTRW-1:0]  rd_ptr;
    logic             do_push;
    logic             do_pop;

    function automatic logic [PTRW-1:0] next_ptr(input logic [PTRW-1:0] p);
        return (p == PTRW'(DEPTH - 1)) ? '0 : p + 1'b1;
    endfunction

    assign do_push = push && !clear && (occupancy != CW'(DEPTH));
    assign do_pop  = pop && !clear && (occupancy != '0);
    assign head    = mem[rd_ptr];

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            wr_ptr    <= '0;
            rd_ptr    <= '0;
            occupancy <= '0;
        end else if (clear) begin
            wr_ptr    <= '0;
            rd_ptr    <= '0;
            occupancy <= '0;
        end else begin
            if (do_push) wr_ptr <= next_ptr(wr_ptr);
            if (do_pop)  rd_ptr <= next_ptr(rd_ptr);
            case ({do_push, do_pop})
                2'b10:   occupancy <= occupancy + 1'b1;
                2'b01:   occupancy <= occupancy - 1'b1;
                default: occupancy <= occupancy;
            endcase
        end
    end

    always_ff @(posedge clk) begin
        if (do_push) mem[wr_ptr] <= push_data;
    end

endmodule

// File: rtl/fifo_stream_rd.sv
// Reads a fixed-latency FIFO and presents the words as a valid/ready stream with packet framing.
// Define FIFO_STREAM_RD_STAT_EN to add the saturating stat_beats transfer counter.
module fifo_stream_rd
    import fifo_stream_pkg::*;
#(
    parameter int WIDTH  = 8,
    parameter int RDLAT  = 2,
    parameter int DEPTH  = 4,
    parameter int PKTLEN = 16
) (
    input  logic             clk,
    input  logic             rst,
    output logic             fifo_read,
    input  logic             fifo_empty,
    input  logic [WIDTH-1:0] fifo_q,
    input  logic             flush,
    output logic             busy,
    output logic [WIDTH-1:0] out_data,
    output logic             out_valid,
    input  logic             out_ready,
    output logic             out_last
`ifdef FIFO_STREAM_RD_STAT_EN
    ,
    output logic [STAT_WIDTH-1:0] stat_beats
`endif
);

    localparam int CW = $clog2(DEPTH + 1);
    localparam int BW = (PKTLEN > 1) ? $clog2(PKTLEN) : 1;

    generate
        if (DEPTH < min_depth(RDLAT) || RDLAT < 1 || RDLAT > 2 || PKTLEN < 1) begin : g_bad_params
            $error("fifo_stream_rd: illegal RDLAT/DEPTH/PKTLEN combination");
        end
    endgenerate

    state_t           state;
    state_t           state_next;
    logic [RDLAT-1:0] rd_pipe;
    logic [CW-1:0]    inflight;
    logic [CW-1:0]    occupancy;
    logic [CW:0]      pending;
    logic             credit;
    logic             returning;
    logic             buf_push;
    logic             buf_clear;
    logic [WIDTH-1:0] head;
    logic             xfer;
    logic [BW-1:0]    beat_cnt;

    sfifo_small #(
        .WIDTH(WIDTH),
        .DEPTH(DEPTH)
    ) u_buf (
        .clk      (clk),
        .rst      (rst),
        .clear    (buf_clear),
        .push     (buf_push),
        .push_data(fifo_q),
        .pop      (xfer),
        .head     (head),
        .occupancy(occupancy)
    );

    always_comb begin
        inflight = '0;
        for (int i = 0; i < RDLAT; i++) begin
            inflight = inflight + CW'(rd_pipe[i]);
        end
    end

    // Words still in the FIFO pipeline already own a buffer slot; a pop in this cycle frees nothing yet.
    assign pending   = {1'b0, inflight} + {1'b0, occupancy};
    assign credit    = pending < (CW + 1)'(DEPTH);
    assign returning = rd_pipe[RDLAT-1];
    assign out_valid = (state == ST_RUN) && (occupancy != '0);
    assign out_data  = out_valid ? head : '0;
    assign xfer      = out_valid && out_ready;
    assign out_last  = out_valid && (beat_cnt == BW'(PKTLEN - 1));

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state   <= ST_RUN;
            rd_pipe <= '0;
        end else begin
            state      <= state_next;
            rd_pipe[0] <= fifo_read;
            for (int i = 1; i < RDLAT; i++) begin
                rd_pipe[i] <= rd_pipe[i-1];
            end
        end
    end

    always_comb begin
        state_next = state;
        fifo_read  = 1'b0;
        busy       = 1'b0;
        buf_push   = 1'b0;
        buf_clear  = 1'b0;
        case (state)
            ST_RUN: begin
                fifo_read = !fifo_empty && credit;
                buf_push  = returning;
                if (flush) begin
                    state_next = ST_FLUSH;
                    buf_clear  = 1'b1;
                end
            end
            ST_FLUSH: begin
                busy      = 1'b1;
                fifo_read = !fifo_empty;
                if (!flush && inflight == '0) state_next = ST_RUN;
            end
            default: state_next = ST_RUN;
        endcase
        if (rst) fifo_read = 1'b0;
    end

    // A beat accepted in the same cycle as flush still framed out_last; the count clears afterwards.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            beat_cnt <= '0;
        end else if (state == ST_RUN && flush) begin
            beat_cnt <= '0;
        end else if (xfer) begin
            beat_cnt <= (beat_cnt == BW'(PKTLEN - 1)) ? '0 : beat_cnt + 1'b1;
        end
    end

`ifdef FIFO_STREAM_RD_STAT_EN
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            stat_beats <= '0;
        end else if (xfer && stat_beats != '1) begin
            stat_beats <= stat_beats + 1'b1;
        end
    end
`endif

endmodule

// File: tb/tb_fifo_stream_rd.sv
// Directed testbench for fifo_stream_rd (RDLAT=2, DEPTH=4, PKTLEN=4) with a behavioural FIFO model.
module tb_fifo_stream_rd;

    localparam int WIDTH  = 8;
    localparam int RDLAT  = 2;
    localparam int DEPTH  = 4;
    localparam int PKTLEN = 4;

    logic             clk = 1'b0;
    logic             rst;
    logic             fifo_read;
    logic             fifo_empty;
    logic [WIDTH-1:0] fifo_q = '0;
    logic             flush;
    logic             busy;
    logic [WIDTH-1:0] out_data;
    logic             out_valid;
    logic             out_ready;
    logic             out_last;
`ifdef FIFO_STREAM_RD_STAT_EN
    logic [31:0]      stat_beats;
`endif

    int compared   = 0;
    int mismatched = 0;
    int cyc;
    int viol;
    bit rand_empty  = 1'b0;
    bit force_empty = 1'b0;

    logic [WIDTH-1:0] mq[$];
    logic [WIDTH-1:0] r1 = '0;
    logic [WIDTH-1:0] got_d[$];
    bit               got_l[$];
    int               got_c[$];
    int               rd_c[$];

    always #5 clk = ~clk;

    fifo_stream_rd #(
        .WIDTH (WIDTH),
        .RDLAT (RDLAT),
        .DEPTH (DEPTH),
        .PKTLEN(PKTLEN)
    ) dut (
        .clk       (clk),
        .rst       (rst),
        .fifo_read (fifo_read),
        .fifo_empty(fifo_empty),
        .fifo_q    (fifo_q),
        .flush     (flush),
        .busy      (busy),
        .out_data  (out_data),
        .out_valid (out_valid),
        .out_ready (out_ready),
        .out_last  (out_last)
`ifdef FIFO_STREAM_RD_STAT_EN
        ,
        .stat_beats(stat_beats)
`endif
    );

    // Two-cycle read latency FIFO: data read in cycle t is on fifo_q during cycle t+2.
    always @(posedge clk) begin
        fifo_q <= r1;
        if (fifo_read && mq.size() > 0) r1 <= mq.pop_front();
        else r1 <= '0;
    end

    function void update_empty();
        fifo_empty = (mq.size() == 0) || force_empty;
    endfunction

    task tick();
        #1;
        if (fifo_read) rd_c.push_back(cyc);
        if (fifo_read && fifo_empty) viol++;
        if (out_valid && out_ready) begin
            got_d.push_back(out_data);
            got_l.push_back(out_last);
            got_c.push_back(cyc);
        end
        @(posedge clk);
        #1;
        cyc++;
        if (rand_empty) force_empty = ($urandom_range(0, 1) == 1);
        update_empty();
    endtask

    task clear_logs();
        got_d.delete();
        got_l.delete();
        got_c.delete();
        rd_c.delete();
        viol = 0;
        cyc  = 0;
    endtask

    task start_test(input int nwords, input logic [WIDTH-1:0] base);
        rst         = 1'b1;
        flush       = 1'b0;
        out_ready   = 1'b0;
        rand_empty  = 1'b0;
        force_empty = 1'b0;
        repeat (2) @(posedge clk);
        #1;
        mq.delete();
        for (int i = 0; i < nwords; i++) mq.push_back(base + WIDTH'(i));
        update_empty();
        rst = 1'b0;
        clear_logs();
    endtask

    task test_reset();
        rst       = 1'b1;
        flush     = 1'b0;
        out_ready = 1'b1;
        mq.delete();
        for (int i = 0; i < 3; i++) mq.push_back(WIDTH'(8'hA0 + i));
        update_empty();
        #2;
        compared++; if (fifo_read !== 1'b0) begin mismatched++; $display("[TB] FAIL reset_fifo_read: got %b expected 0", fifo_read); end
        compared++; if (out_valid !== 1'b0) begin mismatched++; $display("[TB] FAIL reset_out_valid: got %b expected 0", out_valid); end
        compared++; if (out_last !== 1'b0) begin mismatched++; $display("[TB] FAIL reset_out_last: got %b expected 0", out_last); end
        compared++; if (busy !== 1'b0) begin mismatched++; $display("[TB] FAIL reset_busy: got %b expected 0", busy); end
        compared++; if (out_data !== 8'h00) begin mismatched++; $display("[TB] FAIL reset_out_data: got %h expected 00", out_data); end
        @(posedge clk);
        #1;
        compared++; if (fifo_read !== 1'b0) begin mismatched++; $display("[TB] FAIL reset_hold_fifo_read: got %b expected 0", fifo_read); end
    endtask

    task test_basic();
        start_test(5, 8'h01);
        out_ready = 1'b1;
        #1;
        compared++; if (fifo_read !== 1'b1) begin mismatched++; $display("[TB] FAIL basic_first_read: got %b expected 1", fifo_read); end
        repeat (12) tick();
        compared++; if (rd_c.size() != 5) begin mismatched++; $display("[TB] FAIL basic_read_count: got %0d expected 5", rd_c.size()); end
        compared++; if (got_d.size() != 5) begin mismatched++; $display("[TB] FAIL basic_beat_count: got %0d expected 5", got_d.size()); end
        for (int i = 0; i < 5 && i < got_d.size(); i++) begin
            compared++; if (got_d[i] !== WIDTH'(i + 1)) begin mismatched++; $display("[TB] FAIL basic_data[%0d]: got %h expected %h", i, got_d[i], WIDTH'(i + 1)); end
            compared++; if (got_c[i] != 3 + i) begin mismatched++; $display("[TB] FAIL basic_cycle[%0d]: got %0d expected %0d", i, got_c[i], 3 + i); end
            compared++; if (got_l[i] != (i == 3)) begin mismatched++; $display("[TB] FAIL basic_last[%0d]: got %0d expected %0d", i, got_l[i], (i == 3)); end
        end
`ifdef FIFO_STREAM_RD_STAT_EN
        compared++; if (stat_beats !== 32'd5) begin mismatched++; $display("[TB] FAIL basic_stat_beats: got %0d expected 5", stat_beats); end
`endif
    endtask

    task test_stall_and_packets();
        start_test(10, 8'h01);
        for (int k = 0; k < 12; k++) begin
            tick();
            if (cyc >= 3) begin
                compared++; if (out_valid !== 1'b1) begin mismatched++; $display("[TB] FAIL stall_valid@%0d: got %b expected 1", cyc, out_valid); end
                compared++; if (out_data !== 8'h01) begin mismatched++; $display("[TB] FAIL stall_data@%0d: got %h expected 01", cyc, out_data); end
            end
        end
        compared++; if (rd_c.size() != DEPTH) begin mismatched++; $display("[TB] FAIL stall_read_count: got %0d expected %0d", rd_c.size(), DEPTH); end
        compared++; if (mq.size() != 6) begin mismatched++; $display("[TB] FAIL stall_fifo_left: got %0d expected 6", mq.size()); end
        out_ready = 1'b1;
        repeat (20) tick();
        compared++; if (got_d.size() != 10) begin mismatched++; $display("[TB] FAIL pkt_beat_count: got %0d expected 10", got_d.size()); end
        for (int i = 0; i < 10 && i < got_d.size(); i++) begin
            compared++; if (got_d[i] !== WIDTH'(i + 1)) begin mismatched++; $display("[TB] FAIL pkt_data[%0d]: got %h expected %h", i, got_d[i], WIDTH'(i + 1)); end
            compared++; if (got_l[i] != ((i % PKTLEN) == PKTLEN - 1)) begin mismatched++; $display("[TB] FAIL pkt_last[%0d]: got %0d expected %0d", i, got_l[i], ((i % PKTLEN) == PKTLEN - 1)); end
        end
        compared++; if (viol != 0) begin mismatched++; $display("[TB] FAIL stall_read_when_empty: got %0d expected 0", viol); end
    endtask

    task test_flush();
        start_test(6, 8'h11);
        repeat (4) tick();
        compared++; if (out_valid !== 1'b1 || out_data !== 8'h11) begin mismatched++; $display("[TB] FAIL flush_pre: got valid %b data %h expected 1/11", out_valid, out_data); end
        flush = 1'b1;
        tick();
        flush = 1'b0;
        for (int k = 5; k <= 9; k++) begin
            compared++; if (busy !== 1'b1) begin mismatched++; $display("[TB] FAIL flush_busy@%0d: got %b expected 1", cyc, busy); end
            compared++; if (out_valid !== 1'b0) begin mismatched++; $display("[TB] FAIL flush_valid@%0d: got %b expected 0", cyc, out_valid); end
            tick();
        end
        compared++; if (busy !== 1'b0) begin mismatched++; $display("[TB] FAIL flush_exit_busy: got %b expected 0", busy); end
        compared++; if (mq.size() != 0) begin mismatched++; $display("[TB] FAIL flush_drained: got %0d expected 0", mq.size()); end
        mq.push_back(8'h77);
        update_empty();
        out_ready = 1'b1;
        repeat (8) tick();
        compared++; if (got_d.size() != 1) begin mismatched++; $display("[TB] FAIL flush_after_count: got %0d expected 1", got_d.size()); end
        if (got_d.size() > 0) begin
            compared++; if (got_d[0] !== 8'h77) begin mismatched++; $display("[TB] FAIL flush_after_data: got %h expected 77", got_d[0]); end
            compared++; if (got_l[0] != 1'b0) begin mismatched++; $display("[TB] FAIL flush_after_last: got %0d expected 0", got_l[0]); end
        end
    endtask

    task test_random_empty();
        start_test(20, 8'h40);
        out_ready  = 1'b1;
        rand_empty = 1'b1;
        repeat (60) tick();
        rand_empty  = 1'b0;
        force_empty = 1'b0;
        update_empty();
        repeat (40) tick();
        compared++; if (viol != 0) begin mismatched++; $display("[TB] FAIL rand_read_when_empty: got %0d expected 0", viol); end
        compared++; if (got_d.size() != 20) begin mismatched++; $display("[TB] FAIL rand_beat_count: got %0d expected 20", got_d.size()); end
        for (int i = 0; i < 20 && i < got_d.size(); i++) begin
            compared++; if (got_d[i] !== WIDTH'(8'h40 + i)) begin mismatched++; $display("[TB] FAIL rand_data[%0d]: got %h expected %h", i, got_d[i], WIDTH'(8'h40 + i)); end
        end
    endtask

    task test_mid_reset();
        start_test(10, 8'h21);
        out_ready = 1'b1;
        repeat (5) tick();
        compared++; if (got_d.size() != 2) begin mismatched++; $display("[TB] FAIL midrst_pre_count: got %0d expected 2", got_d.size()); end
        rst = 1'b1;
        #1;
        compared++; if (fifo_read !== 1'b0) begin mismatched++; $display("[TB] FAIL midrst_fifo_read: got %b expected 0", fifo_read); end
        compared++; if (out_valid !== 1'b0) begin mismatched++; $display("[TB] FAIL midrst_out_valid: got %b expected 0", out_valid); end
        compared++; if (out_last !== 1'b0) begin mismatched++; $display("[TB] FAIL midrst_out_last: got %b expected 0", out_last); end
        compared++; if (busy !== 1'b0) begin mismatched++; $display("[TB] FAIL midrst_busy: got %b expected 0", busy); end
        compared++; if (out_data !== 8'h00) begin mismatched++; $display("[TB] FAIL midrst_out_data: got %h expected 00", out_data); end
`ifdef FIFO_STREAM_RD_STAT_EN
        compared++; if (stat_beats !== 32'd0) begin mismatched++; $display("[TB] FAIL midrst_stat_beats: got %0d expected 0", stat_beats); end
`endif
        tick();
        rst = 1'b0;
        clear_logs();
        repeat (12) tick();
        compared++; if (got_d.size() != 5) begin mismatched++; $display("[TB] FAIL midrst_after_count: got %0d expected 5", got_d.size()); end
        if (got_d.size() > 0) begin
            compared++; if (got_d[0] !== 8'h26) begin mismatched++; $display("[TB] FAIL midrst_after_data: got %h expected 26", got_d[0]); end
            compared++; if (got_c[0] != 3) begin mismatched++; $display("[TB] FAIL midrst_after_cycle: got %0d expected 3", got_c[0]); end
        end
    endtask

    initial begin
        test_reset();
        test_basic();
        test_stall_and_packets();
        test_flush();
        test_random_empty();
        test_mid_reset();
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
        $finish;
    end

endmodule
